// File: rtl/spi_pkg.sv
// +-----------------------------------------------------------------------+
// | spi_pkg : shared SPI constants (bit order, mode, FSM codes, fill)     |
// | Rev 1.0                                                               |
// +-----------------------------------------------------------------------+
`default_nettype none

package spi_pkg;

  localparam logic MSB_FIRST = 1'b0;
  localparam logic LSB_FIRST = 1'b1;

  // Only mode 0 is implemented; CPOL also gives the sclk idle level.
  localparam logic SPI_CPOL = 1'b0;
  localparam logic SPI_CPHA = 1'b0;

  localparam logic [0:0] ST_IDLE   = 1'b0;
  localparam logic [0:0] ST_ACTIVE = 1'b1;

  localparam logic [7:0] IDLE_FILL_DEFAULT = 8'hFF;

endpackage

`default_nettype wire

// File: rtl/spi_sync_edge.sv
// +-----------------------------------------------------------------------+
// | spi_sync_edge : N-stage synchronizer with rise/fall pulse outputs     |
// | Rev 1.0                                                               |
// +-----------------------------------------------------------------------+
`default_nettype none

module spi_sync_edge #(
  parameter int   STAGES  = 2,
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk_i,
  input  logic arst_n_i,
  input  logic d_i,
  output logic rise_o,
  output logic fall_o
);

  logic [STAGES-1:0] sync_q, sync_d;
  logic              dly_q, dly_d;

  always_comb begin
    sync_d = {sync_q[STAGES-2:0], d_i};
    dly_d  = sync_q[STAGES-1];
  end

  always_ff @(posedge clk_i or negedge arst_n_i) begin
    if (!arst_n_i) begin
      sync_q <= {STAGES{RST_VAL}};
      dly_q  <= RST_VAL;
    end else begin
      sync_q <= sync_d;
      dly_q  <= dly_d;
    end
  end

  assign rise_o = sync_q[STAGES-1] & ~dly_q;
  assign fall_o = ~sync_q[STAGES-1] & dly_q;

endmodule

`default_nettype wire

// File: rtl/spi_slave_exch_byte.sv
// +-----------------------------------------------------------------------+
// | spi_slave_exch_byte : SPI mode-0 target byte exchanger, oversampled   |
// | Rev 1.0                                                               |
// +-----------------------------------------------------------------------+
`default_nettype none

module spi_slave_exch_byte
  import spi_pkg::*;
#(
  parameter int              BYTE        = 8,
  parameter int              SYNC_STAGES = 2,
  parameter logic [BYTE-1:0] IDLE_FILL   = BYTE'(IDLE_FILL_DEFAULT)
) (
  input  logic            clk_i,
  input  logic            arst_n_i,
  input  logic            msb_lsb_sel_i,
  input  logic            sclk_i,
  input  logic            cs_n_i,
  input  logic            mosi_i,
  output logic            miso_o,
  output logic            miso_oe_o,
  input  logic [BYTE-1:0] tx_data_i,
  input  logic            tx_valid_i,
  output logic            tx_ready_o,
  output logic [BYTE-1:0] rx_data_o,
  output logic            rx_valid_o,
  output logic            tx_underrun_o,
  output logic            busy_o
);

  localparam int            CW   = (BYTE > 1) ? $clog2(BYTE) : 1;
  localparam logic [CW-1:0] LAST = CW'(BYTE - 1);

  function automatic logic [BYTE-1:0] bit_rev(input logic [BYTE-1:0] v);
    logic [BYTE-1:0] r;
    for (int i = 0; i < BYTE; i++) r[i] = v[BYTE-1-i];
    return r;
  endfunction

  logic sclk_rise, sclk_fall, cs_rise, cs_fall;

  spi_sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(SPI_CPOL)) u_sclk_sync (
    .clk_i(clk_i), .arst_n_i(arst_n_i), .d_i(sclk_i),
    .rise_o(sclk_rise), .fall_o(sclk_fall)
  );

  spi_sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_cs_sync (
    .clk_i(clk_i), .arst_n_i(arst_n_i), .d_i(cs_n_i),
    .rise_o(cs_rise), .fall_o(cs_fall)
  );

  // mosi shares the sclk pipeline depth so the sampled bit lines up with sclk_rise.
  logic [SYNC_STAGES-1:0] mosi_sync_q, mosi_sync_d;
  logic                   mosi_s;

  logic [0:0]      state_q, state_d;
  logic [BYTE-1:0] hold_q, hold_d, tx_sr_q, tx_sr_d, rx_sr_q, rx_sr_d;
  logic [BYTE-1:0] rx_data_q, rx_data_d, tx_shift;
  logic [CW-1:0]   bitcnt_q, bitcnt_d;
  logic            hold_full_q, hold_full_d, lsb_q, lsb_d;
  logic            miso_q, miso_d, miso_oe_q, miso_oe_d;
  logic            rx_valid_q, rx_valid_d, underrun_q, underrun_d;
  logic            load, wr;

  assign mosi_s = mosi_sync_q[SYNC_STAGES-1];
  assign wr     = tx_valid_i & ~hold_full_q;

  always_comb begin
    mosi_sync_d = {mosi_sync_q[SYNC_STAGES-2:0], mosi_i};
    state_d     = state_q;
    hold_d      = hold_q;
    hold_full_d = hold_full_q;
    tx_sr_d     = tx_sr_q;
    rx_sr_d     = rx_sr_q;
    rx_data_d   = rx_data_q;
    bitcnt_d    = bitcnt_q;
    lsb_d       = lsb_q;
    miso_d      = miso_q;
    miso_oe_d   = miso_oe_q;
    rx_valid_d  = 1'b0;
    underrun_d  = 1'b0;
    load        = 1'b0;
    tx_shift    = tx_sr_q >> 1;

    case (state_q)
      ST_IDLE: begin
        if (cs_fall) begin
          load      = 1'b1;
          bitcnt_d  = '0;
          miso_oe_d = 1'b1;
          state_d   = ST_ACTIVE;
        end
      end
      default: begin
        // Deselect wins over any sclk edge seen in the same cycle.
        if (cs_rise) begin
          state_d   = ST_IDLE;
          bitcnt_d  = '0;
          rx_sr_d   = '0;
          miso_oe_d = 1'b0;
          miso_d    = 1'b1;
        end else if (sclk_rise) begin
          rx_sr_d  = {mosi_s, rx_sr_q[BYTE-1:1]};
          bitcnt_d = bitcnt_q + CW'(1);
          if (bitcnt_q == LAST) begin
            bitcnt_d   = '0;
            rx_data_d  = (lsb_q == LSB_FIRST) ? rx_sr_d : bit_rev(rx_sr_d);
            rx_valid_d = 1'b1;
          end
        end else if (sclk_fall) begin
          if (bitcnt_q != '0) begin
            tx_sr_d = tx_shift;
            miso_d  = tx_shift[0];
          end else begin
            load = 1'b1;
          end
        end
      end
    endcase

    if (load) begin
      lsb_d = msb_lsb_sel_i;
      if (hold_full_q) tx_sr_d = (msb_lsb_sel_i == LSB_FIRST) ? hold_q : bit_rev(hold_q);
      else             tx_sr_d = IDLE_FILL;
      underrun_d  = ~hold_full_q;
      miso_d      = tx_sr_d[0];
      hold_full_d = 1'b0;
    end

    // A write in the load cycle refills the register the load just emptied.
    if (wr) begin
      hold_d      = tx_data_i;
      hold_full_d = 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge arst_n_i) begin
    if (!arst_n_i) begin
      mosi_sync_q <= {SYNC_STAGES{1'b1}};
      state_q     <= ST_IDLE;
      hold_q      <= '0;
      hold_full_q <= 1'b0;
      tx_sr_q     <= '0;
      rx_sr_q     <= '0;
      rx_data_q   <= '0;
      bitcnt_q    <= '0;
      lsb_q       <= 1'b0;
      miso_q      <= 1'b1;
      miso_oe_q   <= 1'b0;
      rx_valid_q  <= 1'b0;
      underrun_q  <= 1'b0;
    end else begin
      mosi_sync_q <= mosi_sync_d;
      state_q     <= state_d;
      hold_q      <= hold_d;
      hold_full_q <= hold_full_d;
      tx_sr_q     <= tx_sr_d;
      rx_sr_q     <= rx_sr_d;
      rx_data_q   <= rx_data_d;
      bitcnt_q    <= bitcnt_d;
      lsb_q       <= lsb_d;
      miso_q      <= miso_d;
      miso_oe_q   <= miso_oe_d;
      rx_valid_q  <= rx_valid_d;
      underrun_q  <= underrun_d;
    end
  end

  assign miso_o        = miso_q;
  assign miso_oe_o     = miso_oe_q;
  assign tx_ready_o    = ~hold_full_q;
  assign rx_data_o     = rx_data_q;
  assign rx_valid_o    = rx_valid_q;
  assign tx_underrun_o = underrun_q;
  assign busy_o        = (state_q == ST_ACTIVE);

endmodule

`default_nettype wire

// File: tb/tb_spi_slave_exch_byte.sv
// +-----------------------------------------------------------------------+
// | tb_spi_slave_exch_byte : scoreboard bench for the SPI target engine   |
// | Rev 1.0                                                               |
// +-----------------------------------------------------------------------+
`default_nettype none

module tb_spi_slave_exch_byte;

  logic       clk_i = 1'b0;
  logic       arst_n_i, msb_lsb_sel_i, sclk_i, cs_n_i, mosi_i;
  logic       tx_valid_i;
  logic [7:0] tx_data_i;
  logic       miso_o, miso_oe_o, tx_ready_o, rx_valid_o, tx_underrun_o, busy_o;
  logic [7:0] rx_data_o;

  int         n_vec = 0;
  int         n_err = 0;
  int         und_cnt = 0;
  logic [7:0] exp_rx_q[$];
  logic       exp_miso_q[$];

  always #5 clk_i = ~clk_i;

  spi_slave_exch_byte dut (
    .clk_i(clk_i), .arst_n_i(arst_n_i), .msb_lsb_sel_i(msb_lsb_sel_i),
    .sclk_i(sclk_i), .cs_n_i(cs_n_i), .mosi_i(mosi_i),
    .miso_o(miso_o), .miso_oe_o(miso_oe_o),
    .tx_data_i(tx_data_i), .tx_valid_i(tx_valid_i), .tx_ready_o(tx_ready_o),
    .rx_data_o(rx_data_o), .rx_valid_o(rx_valid_o),
    .tx_underrun_o(tx_underrun_o), .busy_o(busy_o)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    end
  endtask

  // Receive-side monitor: every rx strobe must match the oldest expected byte.
  always @(negedge clk_i) begin
    if (arst_n_i) begin
      if (tx_underrun_o) und_cnt++;
      if (rx_valid_o) begin
        if (exp_rx_q.size() == 0) chk("rx_queue_entry", exp_rx_q.size(), 1);
        else                      chk("rx_data", rx_data_o, exp_rx_q.pop_front());
      end
    end
  end

  // Master-side sampling of miso at each rising sclk while selected.
  always @(posedge sclk_i) begin
    if (arst_n_i && !cs_n_i) begin
      if (exp_miso_q.size() == 0) chk("miso_queue_entry", exp_miso_q.size(), 1);
      else                        chk("miso_bit", miso_o, exp_miso_q.pop_front());
      chk("miso_oe_active", miso_oe_o, 1);
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(posedge clk_i);
    #2;
  endtask

  task automatic tx_write(input logic [7:0] d);
    tx_data_i  = d;
    tx_valid_i = 1'b1;
    for (int k = 0; k < 200 && !tx_ready_o; k++) cyc(1);
    chk("tx_ready_wait", tx_ready_o, 1);
    cyc(1);
    tx_valid_i = 1'b0;
  endtask

  // Clocks nbits out at clk/8; leaves sclk high so the caller owns the final fall.
  task automatic spi_byte(input logic [7:0] mo, input logic [7:0] mi, input int nbits,
                          input logic lsb);
    if (nbits == 8) exp_rx_q.push_back(mo);
    for (int i = 0; i < nbits; i++) begin
      sclk_i = 1'b0;
      mosi_i = lsb ? mo[i] : mo[7-i];
      exp_miso_q.push_back(lsb ? mi[i] : mi[7-i]);
      cyc(4);
      sclk_i = 1'b1;
      cyc(4);
    end
  endtask

  task automatic deselect();
    sclk_i = 1'b0;
    cyc(4);
    cs_n_i = 1'b1;
    cyc(6);
  endtask

  task automatic select();
    cs_n_i = 1'b0;
    cyc(4);
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_miso"}, miso_o, 1);
    chk({tag, "_miso_oe"}, miso_oe_o, 0);
    chk({tag, "_tx_ready"}, tx_ready_o, 1);
    chk({tag, "_rx_data"}, rx_data_o, 8'h00);
    chk({tag, "_rx_valid"}, rx_valid_o, 0);
    chk({tag, "_underrun"}, tx_underrun_o, 0);
    chk({tag, "_busy"}, busy_o, 0);
  endtask

  initial begin
    #200us;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    arst_n_i = 1'b1; msb_lsb_sel_i = 1'b0; sclk_i = 1'b0; cs_n_i = 1'b1;
    mosi_i = 1'b1; tx_valid_i = 1'b0; tx_data_i = 8'h00;
    #1 arst_n_i = 1'b0;
    cyc(2);
    chk_reset_outputs("reset");
    arst_n_i = 1'b1;
    cyc(3);

    // MSB-first: tx 0xA5 against mosi 0x3C
    tx_write(8'hA5);
    chk("a5_ready_low", tx_ready_o, 0);
    und_cnt = 0;
    select();
    chk("a5_busy", busy_o, 1);
    chk("a5_oe", miso_oe_o, 1);
    chk("a5_ready_after_load", tx_ready_o, 1);
    spi_byte(8'h3C, 8'hA5, 8, 1'b0);
    deselect();
    chk("a5_end_underrun", und_cnt, 1);
    chk("a5_idle_busy", busy_o, 0);
    chk("a5_idle_oe", miso_oe_o, 0);
    chk("a5_idle_miso", miso_o, 1);

    // LSB-first: tx 0x01 against mosi 0x80
    msb_lsb_sel_i = 1'b1;
    tx_write(8'h01);
    select();
    chk("lsb_first_miso", miso_o, 1);
    spi_byte(8'h80, 8'h01, 8, 1'b1);
    deselect();
    chk("lsb_rx_data", rx_data_o, 8'h80);
    msb_lsb_sel_i = 1'b0;

    // Underrun: nothing written, two-byte burst
    und_cnt = 0;
    select();
    spi_byte(8'h12, 8'hFF, 8, 1'b0);
    spi_byte(8'h34, 8'hFF, 8, 1'b0);
    chk("underrun_two_bytes", und_cnt, 2);
    deselect();
    chk("underrun_with_tail", und_cnt, 3);

    // Back-to-back: 0x22 written while 0x11 is shifting out
    tx_write(8'h11);
    select();
    fork
      spi_byte(8'hA1, 8'h11, 8, 1'b0);
      begin
        cyc(20);
        tx_write(8'h22);
        chk("b2b_ready_held", tx_ready_o, 0);
      end
    join
    spi_byte(8'h5E, 8'h22, 8, 1'b0);
    chk("b2b_ready_after_load", tx_ready_o, 1);
    deselect();

    // Abort after 5 bits; next select must send 0x5A intact
    select();
    spi_byte(8'hF0, 8'hFF, 5, 1'b0);
    cs_n_i = 1'b1;
    cyc(6);
    chk("abort_oe", miso_oe_o, 0);
    chk("abort_busy", busy_o, 0);
    chk("abort_miso", miso_o, 1);
    sclk_i = 1'b0;
    cyc(6);
    tx_write(8'h5A);
    select();
    spi_byte(8'h0F, 8'h5A, 8, 1'b0);
    deselect();

    // Reset mid-byte, then a clean 0xC3/0x96 exchange
    tx_write(8'h77);
    select();
    spi_byte(8'h96, 8'h77, 3, 1'b0);
    arst_n_i = 1'b0;
    #1;
    chk_reset_outputs("midreset");
    cs_n_i = 1'b1; sclk_i = 1'b0; mosi_i = 1'b1;
    cyc(3);
    arst_n_i = 1'b1;
    cyc(3);
    tx_write(8'hC3);
    select();
    spi_byte(8'h96, 8'hC3, 8, 1'b0);
    deselect();
    chk("final_rx_data", rx_data_o, 8'h96);

    chk("miso_expect_left", exp_miso_q.size(), 0);
    chk("rx_expect_left", exp_rx_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

`default_nettype wire
